// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port data memory.
// Ports: clk/reset; req/we/addr/wdata per requester; ack/err pulses, rdata, busy;
//        MemWrite/MemRead/address/writeData to memory, readData from memory.
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              MemWrite,
   output logic              MemRead,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] writeData,
   input  logic [DATA_W-1:0] readData
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [ADDR_W-3:0] WORDS_LIM = (ADDR_W-2)'(MEM_WORDS);

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              id_q, id_d;
   logic              we_q, we_d;
   logic              bad_q, bad_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              err0_q, err0_d;
   logic              err1_q, err1_d;
   logic              win;
   logic [ADDR_W-1:0] sel_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         bad_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         we_q    <= we_d;
         bad_q   <= bad_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err0_q  <= err0_d;
         err1_q  <= err1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      we_d     = we_q;
      bad_d    = bad_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      err0_d   = 1'b0;
      err1_d   = 1'b0;
      win      = 1'b0;
      sel_addr = '0;
      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // On contention the port that was not granted last wins.
               win      = (req0 && req1) ? ~last_q : req1;
               sel_addr = win ? addr1 : addr0;
               id_d     = win;
               last_d   = win;
               we_d     = win ? we1 : we0;
               addr_d   = sel_addr;
               wdata_d  = win ? wdata1 : wdata0;
               bad_d    = (sel_addr[1:0] != 2'b00) ||
                          (sel_addr[ADDR_W-1:2] >= WORDS_LIM);
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (!we_q && !bad_q) rdata_d = readData;
            ack0_d  = !bad_q && !id_q;
            ack1_d  = !bad_q &&  id_q;
            err0_d  =  bad_q && !id_q;
            err1_d  =  bad_q &&  id_q;
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are gated by reset so an interrupted write never lands.
   assign MemWrite  = (state_q == ACCESS) && we_q && !bad_q && !reset;
   assign MemRead   = (state_q == ACCESS) && !we_q && !bad_q && !reset;
   assign address   = addr_q;
   assign writeData = wdata_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != IDLE);
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign err0      = err0_q;
   assign err1      = err1_q;

endmodule
